// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and default sizing constants.
package rob_pkg;

   localparam int unsigned ROB_DEPTH = 32;
   localparam int unsigned PREG_W    = 6;
   localparam int unsigned OPC_W     = 7;
   localparam int unsigned DATA_W    = 32;

   // One in-flight instruction as tracked between dispatch and retirement.
   typedef struct packed {
      logic              in_use;
      logic              is_complete;
      logic [PREG_W-1:0] old_d_reg;
      logic [PREG_W-1:0] curr_d_reg;
      logic [OPC_W-1:0]  rd_opcode;
      logic [DATA_W-1:0] rd_value;
      logic [DATA_W-1:0] rs1_value;
   } rob_entry_t;

   // Width needed to count 0..n retired entries.
   function automatic int unsigned retire_cnt_w(int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Picks the contiguous run of retirable entries starting at the head.
module rob_commit_select #(
   parameter int unsigned COMMIT_W = 2,
   parameter int unsigned CNT_W    = 6,
   parameter int unsigned RET_W    = 2
) (
   input  logic [COMMIT_W-1:0] ready_i,
   input  logic [CNT_W-1:0]    count_i,
   output logic [COMMIT_W-1:0] valid_o,
   output logic [RET_W-1:0]    retire_o
);

   // Lane k retires only if it and every older lane are ready and occupied.
   always_comb begin
      logic run;
      run      = 1'b1;
      valid_o  = '0;
      retire_o = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         run        = run & ready_i[k] & (CNT_W'(k) < count_i);
         valid_o[k] = run;
         retire_o   = retire_o + RET_W'(run);
      end
   end

endmodule

// File: rtl/rob_core.sv
// Circular reorder buffer: in-order allocate, out-of-order complete,
// in-order multi-wide commit, with full flush.
module rob_core
   import rob_pkg::*;
#(
   parameter int unsigned DEPTH     = ROB_DEPTH,
   parameter int unsigned CMP_PORTS = 2,
   parameter int unsigned COMMIT_W  = 2,
   localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush_i,
   input  logic                        alloc_valid_i,
   output logic                        alloc_ready_o,
   output logic [IDX_W-1:0]            alloc_idx_o,
   input  logic [OPC_W-1:0]            alloc_opcode_i,
   input  logic [PREG_W-1:0]           alloc_old_preg_i,
   input  logic [PREG_W-1:0]           alloc_new_preg_i,
   input  logic [CMP_PORTS-1:0]        cmp_valid_i,
   input  logic [CMP_PORTS*IDX_W-1:0]  cmp_idx_i,
   input  logic [CMP_PORTS*DATA_W-1:0] cmp_value_i,
   input  logic [CMP_PORTS*DATA_W-1:0] cmp_rs1_value_i,
   output logic [COMMIT_W-1:0]         commit_valid_o,
   output logic [COMMIT_W*PREG_W-1:0]  commit_old_preg_o,
   output logic [COMMIT_W*PREG_W-1:0]  commit_new_preg_o,
   output logic [COMMIT_W*OPC_W-1:0]   commit_opcode_o,
   output logic [COMMIT_W*DATA_W-1:0]  commit_value_o,
   output logic [COMMIT_W*DATA_W-1:0]  commit_rs1_value_o,
   output logic [IDX_W:0]              count_o
);

   localparam int unsigned PTR_W = IDX_W + 1;
   localparam int unsigned RET_W = retire_cnt_w(COMMIT_W);

   rob_entry_t entry_q [DEPTH];
   rob_entry_t entry_d [DEPTH];

   // Pointers carry a wrap bit above the index bits.
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W-1:0] count_q, count_d;

   logic [IDX_W-1:0]    lane_idx [COMMIT_W];
   logic [COMMIT_W-1:0] lane_ready;
   logic [COMMIT_W-1:0] sel_valid;
   logic [RET_W-1:0]    sel_retire;
   logic [RET_W-1:0]    retire;
   logic                alloc_fire;

   // Head-relative view of the oldest COMMIT_W entries.
   always_comb begin
      for (int k = 0; k < COMMIT_W; k++) begin
         lane_idx[k]   = head_q[IDX_W-1:0] + IDX_W'(k);
         lane_ready[k] = entry_q[lane_idx[k]].in_use & entry_q[lane_idx[k]].is_complete;
      end
   end

   rob_commit_select #(
      .COMMIT_W (COMMIT_W),
      .CNT_W    (PTR_W),
      .RET_W    (RET_W)
   ) u_commit_select (
      .ready_i  (lane_ready),
      .count_i  (count_q),
      .valid_o  (sel_valid),
      .retire_o (sel_retire)
   );

   // Flush suppresses retirement; alloc space comes from registered count only.
   assign commit_valid_o = flush_i ? '0 : sel_valid;
   assign retire         = flush_i ? '0 : sel_retire;
   assign alloc_ready_o  = (count_q != PTR_W'(DEPTH));
   assign alloc_idx_o    = tail_q[IDX_W-1:0];
   assign count_o        = count_q;
   assign alloc_fire     = alloc_valid_i & alloc_ready_o & ~flush_i;

   // Commit lane payloads, read straight from the head entries.
   always_comb begin
      for (int k = 0; k < COMMIT_W; k++) begin
         commit_old_preg_o[k*PREG_W +: PREG_W]  = entry_q[lane_idx[k]].old_d_reg;
         commit_new_preg_o[k*PREG_W +: PREG_W]  = entry_q[lane_idx[k]].curr_d_reg;
         commit_opcode_o[k*OPC_W +: OPC_W]      = entry_q[lane_idx[k]].rd_opcode;
         commit_value_o[k*DATA_W +: DATA_W]     = entry_q[lane_idx[k]].rd_value;
         commit_rs1_value_o[k*DATA_W +: DATA_W] = entry_q[lane_idx[k]].rs1_value;
      end
   end

   // Next state: completions (lower port wins), retirement, allocation, flush.
   always_comb begin
      logic [IDX_W-1:0] cidx;
      cidx    = '0;
      entry_d = entry_q;
      for (int p = CMP_PORTS - 1; p >= 0; p--) begin
         cidx = cmp_idx_i[p*IDX_W +: IDX_W];
         if (cmp_valid_i[p] && entry_q[cidx].in_use) begin
            entry_d[cidx].is_complete = 1'b1;
            entry_d[cidx].rd_value    = cmp_value_i[p*DATA_W +: DATA_W];
            entry_d[cidx].rs1_value   = cmp_rs1_value_i[p*DATA_W +: DATA_W];
         end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
         if (commit_valid_o[k]) begin
            entry_d[lane_idx[k]].in_use      = 1'b0;
            entry_d[lane_idx[k]].is_complete = 1'b0;
         end
      end
      if (alloc_fire) begin
         entry_d[tail_q[IDX_W-1:0]] = '{
            in_use:      1'b1,
            is_complete: 1'b0,
            old_d_reg:   alloc_old_preg_i,
            curr_d_reg:  alloc_new_preg_i,
            rd_opcode:   alloc_opcode_i,
            rd_value:    '0,
            rs1_value:   '0
         };
      end
      head_d  = head_q + PTR_W'(retire);
      tail_d  = tail_q + PTR_W'(alloc_fire);
      count_d = count_q + PTR_W'(alloc_fire) - PTR_W'(retire);
      if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) entry_d[i] = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         entry_q <= entry_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_rob_core.sv
// Self-checking bench for rob_core: directed scenarios plus randomized
// traffic against a program-order queue model.
module tb_rob_core;
   import rob_pkg::*;

   localparam int DEPTH = 32;
   localparam int CMP_PORTS = 2;
   localparam int COMMIT_W = 2;
   localparam int IDX_W = 5;

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic                        flush;
   logic                        alloc_valid;
   logic                        alloc_ready;
   logic [IDX_W-1:0]            alloc_idx;
   logic [OPC_W-1:0]            alloc_opcode;
   logic [PREG_W-1:0]           alloc_old_preg;
   logic [PREG_W-1:0]           alloc_new_preg;
   logic [CMP_PORTS-1:0]        cmp_valid;
   logic [CMP_PORTS*IDX_W-1:0]  cmp_idx;
   logic [CMP_PORTS*DATA_W-1:0] cmp_value;
   logic [CMP_PORTS*DATA_W-1:0] cmp_rs1_value;
   logic [COMMIT_W-1:0]         commit_valid;
   logic [COMMIT_W*PREG_W-1:0]  commit_old_preg;
   logic [COMMIT_W*PREG_W-1:0]  commit_new_preg;
   logic [COMMIT_W*OPC_W-1:0]   commit_opcode;
   logic [COMMIT_W*DATA_W-1:0]  commit_value;
   logic [COMMIT_W*DATA_W-1:0]  commit_rs1_value;
   logic [IDX_W:0]              count;

   int n_checks = 0;
   int n_errs = 0;

   // Model: program-order queue of live indices plus per-index payloads.
   int          q[$];
   bit          m_use [DEPTH];
   bit          m_cmp [DEPTH];
   logic [31:0] m_val [DEPTH];
   logic [31:0] m_rs1 [DEPTH];
   logic [5:0]  m_old [DEPTH];
   logic [5:0]  m_new [DEPTH];
   logic [6:0]  m_opc [DEPTH];
   int          m_tail;

   rob_core #(
      .DEPTH     (DEPTH),
      .CMP_PORTS (CMP_PORTS),
      .COMMIT_W  (COMMIT_W)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .flush_i            (flush),
      .alloc_valid_i      (alloc_valid),
      .alloc_ready_o      (alloc_ready),
      .alloc_idx_o        (alloc_idx),
      .alloc_opcode_i     (alloc_opcode),
      .alloc_old_preg_i   (alloc_old_preg),
      .alloc_new_preg_i   (alloc_new_preg),
      .cmp_valid_i        (cmp_valid),
      .cmp_idx_i          (cmp_idx),
      .cmp_value_i        (cmp_value),
      .cmp_rs1_value_i    (cmp_rs1_value),
      .commit_valid_o     (commit_valid),
      .commit_old_preg_o  (commit_old_preg),
      .commit_new_preg_o  (commit_new_preg),
      .commit_opcode_o    (commit_opcode),
      .commit_value_o     (commit_value),
      .commit_rs1_value_o (commit_rs1_value),
      .count_o            (count)
   );

   always #5 clk = ~clk;

   function automatic void model_clear();
      q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         m_use[i] = 1'b0;
         m_cmp[i] = 1'b0;
      end
      m_tail = 0;
   endfunction

   function automatic int exp_ncommit();
      int n = 0;
      while (n < COMMIT_W && n < q.size() && m_cmp[q[n]]) n++;
      return n;
   endfunction

   // Advance the model by one clock using the currently driven inputs, then step the DUT.
   task automatic tick();
      int  n;
      int  ci;
      bit  room;
      if (flush) begin
         @(posedge clk);
         #1;
         model_clear();
         return;
      end
      n    = exp_ncommit();
      room = (q.size() < DEPTH);
      for (int p = CMP_PORTS - 1; p >= 0; p--) begin
         ci = int'(cmp_idx[p*IDX_W +: IDX_W]);
         if (cmp_valid[p] && m_use[ci]) begin
            m_cmp[ci] = 1'b1;
            m_val[ci] = cmp_value[p*32 +: 32];
            m_rs1[ci] = cmp_rs1_value[p*32 +: 32];
         end
      end
      repeat (n) begin
         ci = q.pop_front();
         m_use[ci] = 1'b0;
         m_cmp[ci] = 1'b0;
      end
      if (alloc_valid && room) begin
         q.push_back(m_tail);
         m_use[m_tail] = 1'b1;
         m_cmp[m_tail] = 1'b0;
         m_old[m_tail] = alloc_old_preg;
         m_new[m_tail] = alloc_new_preg;
         m_opc[m_tail] = alloc_opcode;
         m_tail = (m_tail + 1) % DEPTH;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush       = 1'b0;
      alloc_valid = 1'b0;
      cmp_valid   = '0;
   endtask

   task automatic rand_alloc_fields();
      alloc_opcode   = 7'($urandom);
      alloc_old_preg = 6'($urandom);
      alloc_new_preg = 6'($urandom);
   endtask

   task automatic set_cmp(input int p, input int idx, input logic [31:0] v, input logic [31:0] r);
      cmp_valid[p]               = 1'b1;
      cmp_idx[p*IDX_W +: IDX_W]  = IDX_W'(idx);
      cmp_value[p*32 +: 32]      = v;
      cmp_rs1_value[p*32 +: 32]  = r;
   endtask

   task automatic do_alloc();
      alloc_valid = 1'b1;
      rand_alloc_fields();
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic apply_reset();
      idle();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      cmp_idx = '0; cmp_value = '0; cmp_rs1_value = '0;
      rand_alloc_fields();
      #3;
      n_checks++; if (count !== 6'd0) begin n_errs++; $display("FAIL reset_count got=%0d want=0", count); end
      n_checks++; if (alloc_ready !== 1'b1) begin n_errs++; $display("FAIL reset_ready got=%b want=1", alloc_ready); end
      n_checks++; if (alloc_idx !== 5'd0) begin n_errs++; $display("FAIL reset_idx got=%0d want=0", alloc_idx); end
      n_checks++; if (commit_valid !== 2'b00) begin n_errs++; $display("FAIL reset_commit got=%b want=00", commit_valid); end
      rst_n = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
   endtask

   task automatic test_async_reset();
      apply_reset();
      repeat (5) do_alloc();
      set_cmp(0, 0, 32'h1234, 32'h5678);
      tick();
      idle();
      #1;
      n_checks++; if (count !== 6'd5) begin n_errs++; $display("FAIL areset_pre_count got=%0d want=5", count); end
      n_checks++; if (commit_valid !== 2'b01) begin n_errs++; $display("FAIL areset_pre_commit got=%b want=01", commit_valid); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (count !== 6'd0) begin n_errs++; $display("FAIL areset_count got=%0d want=0", count); end
      n_checks++; if (alloc_ready !== 1'b1) begin n_errs++; $display("FAIL areset_ready got=%b want=1", alloc_ready); end
      n_checks++; if (alloc_idx !== 5'd0) begin n_errs++; $display("FAIL areset_idx got=%0d want=0", alloc_idx); end
      n_checks++; if (commit_valid !== 2'b00) begin n_errs++; $display("FAIL areset_commit got=%b want=00", commit_valid); end
      rst_n = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill();
      apply_reset();
      for (int i = 0; i < DEPTH; i++) begin
         alloc_valid = 1'b1;
         rand_alloc_fields();
         #1;
         n_checks++; if (alloc_idx !== 5'(i)) begin n_errs++; $display("FAIL fill_idx got=%0d want=%0d", alloc_idx, i); end
         n_checks++; if (alloc_ready !== 1'b1) begin n_errs++; $display("FAIL fill_ready[%0d] got=%b want=1", i, alloc_ready); end
         tick();
      end
      n_checks++; if (count !== 6'd32) begin n_errs++; $display("FAIL fill_count got=%0d want=32", count); end
      n_checks++; if (alloc_ready !== 1'b0) begin n_errs++; $display("FAIL fill_full_ready got=%b want=0", alloc_ready); end
      tick();
      idle();
      n_checks++; if (count !== 6'd32) begin n_errs++; $display("FAIL fill_over_count got=%0d want=32", count); end
      n_checks++; if (alloc_idx !== 5'd0) begin n_errs++; $display("FAIL fill_over_tail got=%0d want=0", alloc_idx); end
   endtask

   task automatic test_out_of_order();
      logic [31:0] v [3];
      apply_reset();
      repeat (3) do_alloc();
      for (int i = 0; i < 3; i++) v[i] = $urandom;
      set_cmp(0, 2, v[2], 32'h2); tick(); idle(); #1;
      n_checks++; if (commit_valid !== 2'b00) begin n_errs++; $display("FAIL ooo_c2 got=%b want=00", commit_valid); end
      set_cmp(0, 1, v[1], 32'h1); tick(); idle(); #1;
      n_checks++; if (commit_valid !== 2'b00) begin n_errs++; $display("FAIL ooo_c1 got=%b want=00", commit_valid); end
      set_cmp(0, 0, v[0], 32'h0); tick(); idle(); #1;
      n_checks++; if (commit_valid !== 2'b11) begin n_errs++; $display("FAIL ooo_c0 got=%b want=11", commit_valid); end
      n_checks++; if (commit_value !== {v[1], v[0]}) begin n_errs++; $display("FAIL ooo_vals got=%h want=%h", commit_value, {v[1], v[0]}); end
      tick();
      n_checks++; if (commit_valid !== 2'b01) begin n_errs++; $display("FAIL ooo_last got=%b want=01", commit_valid); end
      n_checks++; if (commit_value[31:0] !== v[2]) begin n_errs++; $display("FAIL ooo_last_val got=%h want=%h", commit_value[31:0], v[2]); end
      tick();
      n_checks++; if (count !== 6'd0) begin n_errs++; $display("FAIL ooo_count got=%0d want=0", count); end
   endtask

   task automatic test_same_cycle();
      apply_reset();
      repeat (2) do_alloc();
      set_cmp(0, 0, 32'hAA, 32'h1);
      set_cmp(1, 0, 32'hBB, 32'h2);
      tick();
      idle();
      set_cmp(0, 1, 32'h11, 32'h3);
      #1;
      n_checks++; if (commit_valid !== 2'b01) begin n_errs++; $display("FAIL same_first got=%b want=01", commit_valid); end
      n_checks++; if (commit_value[31:0] !== 32'hAA) begin n_errs++; $display("FAIL same_port_prio got=%h want=aa", commit_value[31:0]); end
      n_checks++; if (commit_rs1_value[31:0] !== 32'h1) begin n_errs++; $display("FAIL same_rs1 got=%h want=1", commit_rs1_value[31:0]); end
      tick();
      idle();
      #1;
      n_checks++; if (commit_valid !== 2'b01) begin n_errs++; $display("FAIL same_next got=%b want=01", commit_valid); end
      n_checks++; if (commit_value[31:0] !== 32'h11) begin n_errs++; $display("FAIL same_next_val got=%h want=11", commit_value[31:0]); end
      tick();
      n_checks++; if (count !== 6'd0) begin n_errs++; $display("FAIL same_count got=%0d want=0", count); end
   endtask

   task automatic test_wrap();
      int guard;
      int exp_idx [4] = '{30, 31, 0, 1};
      apply_reset();
      repeat (30) do_alloc();
      for (int j = 0; j < 15; j++) begin
         set_cmp(0, 2 * j, $urandom, $urandom);
         set_cmp(1, 2 * j + 1, $urandom, $urandom);
         tick();
         idle();
      end
      guard = 0;
      while (count !== 6'd0 && guard < 20) begin
         tick();
         guard++;
      end
      n_checks++; if (count !== 6'd0) begin n_errs++; $display("FAIL wrap_drain got=%0d want=0", count); end
      n_checks++; if (alloc_idx !== 5'd30) begin n_errs++; $display("FAIL wrap_tail got=%0d want=30", alloc_idx); end
      for (int i = 0; i < 4; i++) begin
         alloc_valid = 1'b1;
         rand_alloc_fields();
         #1;
         n_checks++; if (alloc_idx !== 5'(exp_idx[i])) begin n_errs++; $display("FAIL wrap_idx got=%0d want=%0d", alloc_idx, exp_idx[i]); end
         tick();
      end
      idle();
      set_cmp(0, 30, $urandom, $urandom);
      set_cmp(1, 31, $urandom, $urandom);
      tick();
      idle();
      set_cmp(0, 0, $urandom, $urandom);
      set_cmp(1, 1, $urandom, $urandom);
      #1;
      n_checks++; if (commit_valid !== 2'b11) begin n_errs++; $display("FAIL wrap_c30 got=%b want=11", commit_valid); end
      n_checks++; if (commit_value !== {m_val[31], m_val[30]}) begin n_errs++; $display("FAIL wrap_v30 got=%h want=%h", commit_value, {m_val[31], m_val[30]}); end
      n_checks++; if (commit_new_preg !== {m_new[31], m_new[30]}) begin n_errs++; $display("FAIL wrap_p30 got=%h want=%h", commit_new_preg, {m_new[31], m_new[30]}); end
      tick();
      idle();
      #1;
      n_checks++; if (commit_valid !== 2'b11) begin n_errs++; $display("FAIL wrap_c0 got=%b want=11", commit_valid); end
      n_checks++; if (commit_value !== {m_val[1], m_val[0]}) begin n_errs++; $display("FAIL wrap_v0 got=%h want=%h", commit_value, {m_val[1], m_val[0]}); end
      tick();
      n_checks++; if (count !== 6'd0) begin n_errs++; $display("FAIL wrap_empty got=%0d want=0", count); end
      n_checks++; if (commit_valid !== 2'b00) begin n_errs++; $display("FAIL wrap_idle got=%b want=00", commit_valid); end
      n_checks++; if (alloc_idx !== 5'd2) begin n_errs++; $display("FAIL wrap_end_tail got=%0d want=2", alloc_idx); end
   endtask

   task automatic test_flush();
      apply_reset();
      repeat (7) do_alloc();
      set_cmp(0, 0, $urandom, $urandom);
      set_cmp(1, 1, $urandom, $urandom);
      tick();
      idle();
      #1;
      n_checks++; if (commit_valid !== 2'b11) begin n_errs++; $display("FAIL flush_pre got=%b want=11", commit_valid); end
      n_checks++; if (count !== 6'd7) begin n_errs++; $display("FAIL flush_pre_count got=%0d want=7", count); end
      flush = 1'b1;
      alloc_valid = 1'b1;
      set_cmp(0, 3, $urandom, $urandom);
      #1;
      n_checks++; if (commit_valid !== 2'b00) begin n_errs++; $display("FAIL flush_commit got=%b want=00", commit_valid); end
      tick();
      idle();
      #1;
      n_checks++; if (count !== 6'd0) begin n_errs++; $display("FAIL flush_count got=%0d want=0", count); end
      n_checks++; if (alloc_idx !== 5'd0) begin n_errs++; $display("FAIL flush_idx got=%0d want=0", alloc_idx); end
      n_checks++; if (alloc_ready !== 1'b1) begin n_errs++; $display("FAIL flush_ready got=%b want=1", alloc_ready); end
      set_cmp(0, 3, $urandom, $urandom);
      tick();
      idle();
      repeat (4) do_alloc();
      set_cmp(0, 0, $urandom, $urandom);
      set_cmp(1, 1, $urandom, $urandom);
      tick();
      idle();
      set_cmp(0, 2, $urandom, $urandom);
      tick();
      idle();
      tick();
      tick();
      n_checks++; if (count !== 6'd1) begin n_errs++; $display("FAIL flush_stale_count got=%0d want=1", count); end
      n_checks++; if (commit_valid !== 2'b00) begin n_errs++; $display("FAIL flush_stale_commit got=%b want=00", commit_valid); end
   endtask

   task automatic test_random();
      int          n;
      int          e;
      logic [1:0]  exp_mask;
      apply_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         flush       = ($urandom_range(0, 199) == 0);
         alloc_valid = ($urandom_range(0, 99) < 55);
         rand_alloc_fields();
         cmp_valid = '0;
         for (int p = 0; p < CMP_PORTS; p++) begin
            if ($urandom_range(0, 99) < 60) begin
               if (q.size() > 0 && $urandom_range(0, 99) < 85)
                  set_cmp(p, q[$urandom_range(0, q.size() - 1)], $urandom, $urandom);
               else
                  set_cmp(p, $urandom_range(0, DEPTH - 1), $urandom, $urandom);
            end
         end
         #1;
         n = flush ? 0 : exp_ncommit();
         exp_mask = 2'((1 << n) - 1);
         n_checks++; if (alloc_ready !== (q.size() < DEPTH)) begin n_errs++; $display("FAIL rnd_ready c%0d got=%b want=%b", cyc, alloc_ready, q.size() < DEPTH); end
         n_checks++; if (alloc_idx !== 5'(m_tail)) begin n_errs++; $display("FAIL rnd_idx c%0d got=%0d want=%0d", cyc, alloc_idx, m_tail); end
         n_checks++; if (count !== 6'(q.size())) begin n_errs++; $display("FAIL rnd_count c%0d got=%0d want=%0d", cyc, count, q.size()); end
         n_checks++; if (commit_valid !== exp_mask) begin n_errs++; $display("FAIL rnd_commit c%0d got=%b want=%b", cyc, commit_valid, exp_mask); end
         for (int k = 0; k < n; k++) begin
            e = q[k];
            n_checks++;
            if (commit_value[k*32 +: 32] !== m_val[e] || commit_rs1_value[k*32 +: 32] !== m_rs1[e] ||
                commit_old_preg[k*6 +: 6] !== m_old[e] || commit_new_preg[k*6 +: 6] !== m_new[e] ||
                commit_opcode[k*7 +: 7] !== m_opc[e]) begin
               n_errs++;
               $display("FAIL rnd_payload c%0d lane%0d got=%h/%h/%h/%h/%h want=%h/%h/%h/%h/%h", cyc, k,
                        commit_value[k*32 +: 32], commit_rs1_value[k*32 +: 32], commit_old_preg[k*6 +: 6],
                        commit_new_preg[k*6 +: 6], commit_opcode[k*7 +: 7],
                        m_val[e], m_rs1[e], m_old[e], m_new[e], m_opc[e]);
            end
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_async_reset();
      test_fill();
      test_out_of_order();
      test_same_cycle();
      test_wrap();
      test_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached errors=%0d checks=%0d", n_errs, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
